// File: rtl/dma_desc_pkg.sv
// -----------------------------------------------------------------------------
// dma_desc_pkg
// Shared definitions for the DMA descriptor path: descriptor layout, field
// positions, request length width and the splitter state encoding.
// Used by dma_desc_splitter, dma_desc_splitter_if and dma_chunk_calc.
// -----------------------------------------------------------------------------
package dma_desc_pkg;

   localparam int unsigned DESC_W       = 56;
   localparam int unsigned ADDR_W       = 40;
   localparam int unsigned LEN_W        = 16;
   localparam int unsigned REQ_LEN_DW_W = 11;

   // Descriptor field positions: {addr[39:0], len[15:0]}
   localparam int unsigned LEN_LSB  = 0;
   localparam int unsigned LEN_MSB  = LEN_LSB + LEN_W - 1;
   localparam int unsigned ADDR_LSB = 16;
   localparam int unsigned ADDR_MSB = ADDR_LSB + ADDR_W - 1;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   // A descriptor is unusable when it carries no data or is not DWORD aligned
   // in either address or length.
   function automatic logic desc_bad(input logic [ADDR_W-1:0] addr,
                                     input logic [LEN_W-1:0]  len);
      return (len == '0) || (addr[1:0] != 2'b00) || (len[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/dma_desc_splitter_if.sv
// -----------------------------------------------------------------------------
// dma_desc_splitter_if
// Bundles the descriptor FIFO read side and the request valid/ready channel.
//   fifoEmpty  FIFO empty flag
//   fifoData   FIFO head entry {addr, len}
//   fifoPop    pop strobe to FIFO
//   reqValid   request valid
//   reqReady   request accepted when reqValid & reqReady
//   reqAddr    request byte address
//   reqLenDw   request length in DWORDs
//   reqLast    final request of the current descriptor
// Modports: master = splitter side, slave = FIFO / request builder side.
// -----------------------------------------------------------------------------
interface dma_desc_splitter_if;
   import dma_desc_pkg::*;

   logic                    fifoEmpty;
   logic [DESC_W-1:0]       fifoData;
   logic                    fifoPop;
   logic                    reqValid;
   logic                    reqReady;
   logic [ADDR_W-1:0]       reqAddr;
   logic [REQ_LEN_DW_W-1:0] reqLenDw;
   logic                    reqLast;

   modport master (
      input  fifoEmpty, fifoData, reqReady,
      output fifoPop, reqValid, reqAddr, reqLenDw, reqLast
   );

   modport slave (
      output fifoEmpty, fifoData, reqReady,
      input  fifoPop, reqValid, reqAddr, reqLenDw, reqLast
   );

endinterface

// File: rtl/dma_chunk_calc.sv
// -----------------------------------------------------------------------------
// dma_chunk_calc
// Purely combinational: size of the next request so it never crosses a
// MAX_REQ_BYTES-aligned boundary.
//   curAddr     current byte address
//   remBytes    bytes remaining in the descriptor
//   chunkBytes  bytes in the next request
//   isLast      next request finishes the descriptor
// -----------------------------------------------------------------------------
module dma_chunk_calc
   import dma_desc_pkg::*;
#(
   parameter int unsigned MAX_REQ_BYTES = 512
) (
   input  logic [ADDR_W-1:0] curAddr,
   input  logic [LEN_W-1:0]  remBytes,
   output logic [LEN_W-1:0]  chunkBytes,
   output logic              isLast
);

   logic [ADDR_W-1:0] room;

   always_comb begin
      // Bytes left before the next aligned boundary; always 1..MAX_REQ_BYTES,
      // so it fits in LEN_W bits.
      room = ADDR_W'(MAX_REQ_BYTES) - (curAddr & ADDR_W'(MAX_REQ_BYTES - 1));
      if (ADDR_W'(remBytes) <= room) begin
         chunkBytes = remBytes;
         isLast     = 1'b1;
      end else begin
         chunkBytes = LEN_W'(room);
         isLast     = 1'b0;
      end
   end

endmodule

// File: rtl/dma_desc_splitter.sv
// -----------------------------------------------------------------------------
// dma_desc_splitter
// Pops descriptors from the descriptor FIFO and splits each one into read
// requests that never cross a MAX_REQ_BYTES-aligned (hence 4 KB) boundary.
//   clockCore    core clock
//   resetCore    asynchronous active-high reset
//   enable       permits new descriptor pops
//   bus          FIFO read side + request channel (master modport)
//   busy         descriptor in flight
//   errDesc      one-cycle pulse when a descriptor is dropped
//   statDescCnt  accepted descriptor count (DMA_DESC_SPLITTER_STATS_EN only)
//   statReqCnt   request handshake count   (DMA_DESC_SPLITTER_STATS_EN only)
// Optional feature macro: DMA_DESC_SPLITTER_STATS_EN.
// -----------------------------------------------------------------------------
module dma_desc_splitter
   import dma_desc_pkg::*;
#(
   parameter int unsigned MAX_REQ_BYTES = 512
) (
   input  logic                 clockCore,
   input  logic                 resetCore,
   input  logic                 enable,
   dma_desc_splitter_if.master  bus,
   output logic                 busy,
   output logic                 errDesc
`ifdef DMA_DESC_SPLITTER_STATS_EN
   ,
   output logic [15:0]          statDescCnt,
   output logic [15:0]          statReqCnt
`endif
);

   state_t                  state_q;
   logic [ADDR_W-1:0]       reqAddr_q;
   logic [LEN_W-1:0]        remBytes_q;
   logic [REQ_LEN_DW_W-1:0] reqLenDw_q;
   logic                    reqValid_q;
   logic                    reqLast_q;
   logic                    errDesc_q;
`ifdef DMA_DESC_SPLITTER_STATS_EN
   logic [15:0]             statDescCnt_q;
   logic [15:0]             statReqCnt_q;
`endif

   logic              pop;
   logic              accept;
   logic [ADDR_W-1:0] descAddr;
   logic [LEN_W-1:0]  descLen;
   logic [LEN_W-1:0]  curChunk;
   logic [ADDR_W-1:0] addr_d;
   logic [LEN_W-1:0]  remBytes_d;
   logic [ADDR_W-1:0] calcAddr;
   logic [LEN_W-1:0]  calcRem;
   logic [LEN_W-1:0]  calcChunk;
   logic              calcLast;

   assign pop    = ~resetCore & (state_q == IDLE) & enable & ~bus.fifoEmpty;
   assign accept = reqValid_q & bus.reqReady;

   // reqAddr_q doubles as the running address; the size of the request on
   // offer is recovered from reqLenDw_q, so no separate chunk register exists.
   // One chunk calculator serves both the descriptor load and the advance.
   always_comb begin
      descAddr   = bus.fifoData[ADDR_MSB:ADDR_LSB];
      descLen    = bus.fifoData[LEN_MSB:LEN_LSB];
      curChunk   = LEN_W'({reqLenDw_q, 2'b00});
      addr_d     = reqAddr_q + ADDR_W'(curChunk);
      remBytes_d = remBytes_q - curChunk;
      if (state_q == IDLE) begin
         calcAddr = descAddr;
         calcRem  = descLen;
      end else begin
         calcAddr = addr_d;
         calcRem  = remBytes_d;
      end
   end

   dma_chunk_calc #(
      .MAX_REQ_BYTES (MAX_REQ_BYTES)
   ) u_chunk_calc (
      .curAddr    (calcAddr),
      .remBytes   (calcRem),
      .chunkBytes (calcChunk),
      .isLast     (calcLast)
   );

   always_ff @(posedge clockCore or posedge resetCore) begin
      if (resetCore) begin
         state_q       <= IDLE;
         reqAddr_q     <= '0;
         remBytes_q    <= '0;
         reqLenDw_q    <= '0;
         reqValid_q    <= 1'b0;
         reqLast_q     <= 1'b0;
         errDesc_q     <= 1'b0;
`ifdef DMA_DESC_SPLITTER_STATS_EN
         statDescCnt_q <= '0;
         statReqCnt_q  <= '0;
`endif
      end else begin
         errDesc_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  if (desc_bad(descAddr, descLen)) begin
                     errDesc_q <= 1'b1;
                  end else begin
                     reqAddr_q  <= descAddr;
                     remBytes_q <= descLen;
                     reqLenDw_q <= REQ_LEN_DW_W'(calcChunk >> 2);
                     reqLast_q  <= calcLast;
                     reqValid_q <= 1'b1;
                     state_q    <= ISSUE;
`ifdef DMA_DESC_SPLITTER_STATS_EN
                     statDescCnt_q <= statDescCnt_q + 16'd1;
`endif
                  end
               end
            end
            ISSUE: begin
               if (accept) begin
`ifdef DMA_DESC_SPLITTER_STATS_EN
                  statReqCnt_q <= statReqCnt_q + 16'd1;
`endif
                  if (reqLast_q) begin
                     reqValid_q <= 1'b0;
                     state_q    <= IDLE;
                  end else begin
                     reqAddr_q  <= addr_d;
                     remBytes_q <= remBytes_d;
                     reqLenDw_q <= REQ_LEN_DW_W'(calcChunk >> 2);
                     reqLast_q  <= calcLast;
                  end
               end
            end
            default: begin
               state_q    <= IDLE;
               reqValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fifoPop  = pop;
   assign bus.reqValid = reqValid_q;
   assign bus.reqAddr  = reqAddr_q;
   assign bus.reqLenDw = reqLenDw_q;
   assign bus.reqLast  = reqLast_q;
   assign busy         = (state_q != IDLE);
   assign errDesc      = errDesc_q;
`ifdef DMA_DESC_SPLITTER_STATS_EN
   assign statDescCnt  = statDescCnt_q;
   assign statReqCnt   = statReqCnt_q;
`endif

endmodule

// File: tb/tb_dma_desc_splitter.sv
// -----------------------------------------------------------------------------
// tb_dma_desc_splitter
// Directed bench for dma_desc_splitter (MAX_REQ_BYTES = 512). A queue-based
// reference splits each popped descriptor arithmetically; every cycle the
// DUT outputs are compared against it, and hand-computed literals pin the
// key sequences. Honors DMA_DESC_SPLITTER_STATS_EN.
// -----------------------------------------------------------------------------
module tb_dma_desc_splitter;

   localparam int unsigned MAX = 512;

   typedef struct {
      logic [39:0] addr;
      logic [10:0] dw;
      logic        last;
   } req_t;

   logic clockCore = 1'b0;
   logic resetCore;
   logic enable;
   logic busy;
   logic errDesc;
`ifdef DMA_DESC_SPLITTER_STATS_EN
   logic [15:0] statDescCnt;
   logic [15:0] statReqCnt;
`endif

   dma_desc_splitter_if bus ();

   dma_desc_splitter #(
      .MAX_REQ_BYTES (MAX)
   ) dut (
      .clockCore   (clockCore),
      .resetCore   (resetCore),
      .enable      (enable),
      .bus         (bus),
      .busy        (busy),
      .errDesc     (errDesc)
`ifdef DMA_DESC_SPLITTER_STATS_EN
      ,
      .statDescCnt (statDescCnt),
      .statReqCnt  (statReqCnt)
`endif
   );

   always #5 clockCore = ~clockCore;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- FIFO emulation ----------------
   logic [55:0] mem [0:63];
   int rd = 0;
   int wr = 0;

   assign bus.fifoEmpty = (rd == wr);
   assign bus.fifoData  = mem[rd];

   always @(posedge clockCore)
      if (bus.fifoPop) rd <= rd + 1;

   task automatic push(input logic [39:0] a, input logic [15:0] l);
      mem[wr] = {a, l};
      wr++;
   endtask

   // ---------------- reference model ----------------
   req_t        expq[$];
   logic [51:0] logq[$];
   bit          mbusy = 0;
   bit          merr  = 0;
   int unsigned mDesc = 0;
   int unsigned mReq  = 0;

   function automatic void split(input logic [39:0] a, input int unsigned len);
      int unsigned rem = len;
      logic [39:0] addr = a;
      while (rem > 0) begin
         int unsigned room = MAX - int'(addr % 40'(MAX));
         int unsigned c    = (rem < room) ? rem : room;
         req_t r;
         r.addr = addr;
         r.dw   = 11'(c / 4);
         r.last = (c == rem);
         expq.push_back(r);
         addr = addr + 40'(c);
         rem  = rem - c;
      end
   endfunction

   always @(posedge clockCore or posedge resetCore) begin
      if (resetCore) begin
         mbusy = 0;
         merr  = 0;
         mDesc = 0;
         mReq  = 0;
         expq.delete();
      end else begin
         bit          mpop;
         logic [55:0] d;
         mpop = enable && (rd != wr) && !mbusy;
         merr = 0;
         if (bus.reqValid && bus.reqReady)
            logq.push_back({bus.reqAddr, bus.reqLenDw, bus.reqLast});
         if (mbusy && bus.reqReady && expq.size() > 0) begin
            if (expq[0].last) mbusy = 0;
            void'(expq.pop_front());
            mReq++;
         end
         if (mpop) begin
            d = mem[rd];
            if (d[15:0] == 16'h0 || d[17:16] != 2'b00 || d[1:0] != 2'b00) begin
               merr = 1;
            end else begin
               split(d[55:16], int'(d[15:0]));
               mbusy = 1;
               mDesc++;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clockCore) begin
      chk("fifoPop", bus.fifoPop, !resetCore && enable && (rd != wr) && !mbusy);
      chk("busy", busy, mbusy);
      chk("reqValid", bus.reqValid, mbusy);
      chk("errDesc", errDesc, merr);
      if (mbusy && expq.size() > 0) begin
         chk("reqAddr", bus.reqAddr, expq[0].addr);
         chk("reqLenDw", bus.reqLenDw, expq[0].dw);
         chk("reqLast", bus.reqLast, expq[0].last);
      end
`ifdef DMA_DESC_SPLITTER_STATS_EN
      chk("statDescCnt", statDescCnt, 16'(mDesc));
      chk("statReqCnt", statReqCnt, 16'(mReq));
`endif
   end

   // ---------------- helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clockCore);
         #1;
      end
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      while (!(rd == wr && !busy && !bus.reqValid) && n < 300) begin
         step(1);
         n++;
      end
      if (n >= 300) begin
         tests++;
         fails++;
         $display("FAIL %s: timeout waiting for idle, got busy=%0b expected 0", name, busy);
      end
      step(2);
   endtask

   task automatic chk_req(input string name, input int idx, input logic [51:0] exp);
      if (idx < logq.size()) chk(name, logq[idx], exp);
      else begin
         tests++;
         fails++;
         $display("FAIL %s: got no request, expected 0x%0h", name, exp);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int lb;
      int p0;
      int n;
      int errs;
      resetCore    = 1'b1;
      enable       = 1'b0;
      bus.reqReady = 1'b0;
      step(3);
      chk("rst_reqValid", bus.reqValid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_errDesc", errDesc, 0);
      chk("rst_reqAddr", bus.reqAddr, 0);
      chk("rst_reqLenDw", bus.reqLenDw, 0);
      chk("rst_reqLast", bus.reqLast, 0);
      chk("rst_fifoPop", bus.fifoPop, 0);
      resetCore = 1'b0;
      step(2);

      // Basic split: 0x100 / 0x400 across two 512-byte boundaries.
      enable       = 1'b1;
      bus.reqReady = 1'b1;
      lb = logq.size();
      p0 = rd;
      push(40'h00_0000_0100, 16'h0400);
      wait_quiet("t1");
      chk("t1_pops", rd - p0, 1);
      chk("t1_count", logq.size() - lb, 3);
      chk_req("t1_req0", lb + 0, {40'h100, 11'd64, 1'b0});
      chk_req("t1_req1", lb + 1, {40'h200, 11'd128, 1'b0});
      chk_req("t1_req2", lb + 2, {40'h400, 11'd64, 1'b1});

      // Dropped descriptors: zero length, misaligned address, misaligned length.
      lb   = logq.size();
      p0   = rd;
      errs = 0;
      push(40'h00_0000_1000, 16'h0000);
      push(40'h00_0000_0102, 16'h0010);
      push(40'h00_0000_0200, 16'h0006);
      n = 0;
      while ((rd != wr || n < 3) && n < 40) begin
         step(1);
         if (errDesc) errs++;
         n++;
      end
      step(2);
      chk("err_pulses", errs, 3);
      chk("err_pops", rd - p0, 3);
      chk("err_noreq", logq.size() - lb, 0);

      // Address wrap at 2^40.
      lb = logq.size();
      push(40'hFF_FFFF_FF00, 16'h0200);
      wait_quiet("wrap");
      chk_req("wrap_req0", lb + 0, {40'hFF_FFFF_FF00, 11'd64, 1'b0});
      chk_req("wrap_req1", lb + 1, {40'h0, 11'd64, 1'b1});

      // Backpressure on the second request.
      lb = logq.size();
      push(40'h00_0000_0100, 16'h0400);
      n = 0;
      while (logq.size() < lb + 1 && n < 50) begin
         step(1);
         n++;
      end
      bus.reqReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("hold_valid", bus.reqValid, 1);
         chk("hold_addr", bus.reqAddr, 40'h200);
         chk("hold_dw", bus.reqLenDw, 11'd128);
         chk("hold_last", bus.reqLast, 0);
      end
      bus.reqReady = 1'b1;
      wait_quiet("hold");
      chk_req("hold_req1", lb + 1, {40'h200, 11'd128, 1'b0});
      chk_req("hold_req2", lb + 2, {40'h400, 11'd64, 1'b1});

      // Enable gating.
      enable = 1'b0;
      p0 = rd;
      push(40'h00_0000_1000, 16'h0600);
      push(40'h00_0000_2000, 16'h0080);
      step(4);
      chk("en_nopop", rd - p0, 0);
      enable = 1'b1;
      n = 0;
      while (!busy && n < 20) begin
         step(1);
         n++;
      end
      enable = 1'b0;
      n = 0;
      while (busy && n < 50) begin
         step(1);
         n++;
      end
      step(4);
      chk("en_first_only", rd - p0, 1);
      chk("en_fifo_left", wr - rd, 1);
      enable = 1'b1;
      wait_quiet("en");
      chk("en_both", rd - p0, 2);

      // Reset mid-descriptor.
      bus.reqReady = 1'b0;
      lb = logq.size();
      push(40'h00_0000_0000, 16'h0800);
      n = 0;
      while (!bus.reqValid && n < 20) begin
         step(1);
         n++;
      end
      step(2);
      resetCore = 1'b1;
      #1;
      chk("mid_rst_valid", bus.reqValid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_addr", bus.reqAddr, 0);
      chk("mid_rst_dw", bus.reqLenDw, 0);
      chk("mid_rst_last", bus.reqLast, 0);
      chk("mid_rst_pop", bus.fifoPop, 0);
`ifdef DMA_DESC_SPLITTER_STATS_EN
      chk("mid_rst_statDesc", statDescCnt, 0);
      chk("mid_rst_statReq", statReqCnt, 0);
`endif
      step(2);
      resetCore    = 1'b0;
      bus.reqReady = 1'b1;
      step(10);
      chk("post_rst_noreq", logq.size() - lb, 0);
      chk("post_rst_valid", bus.reqValid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dma_desc_splitter.md
Name: dma_desc_splitter

Overview:
- Downstream consumer of the 8-deep x 56-bit descriptor register FIFO in the DMA read path.
- Pops one descriptor at a time, containing a 40-bit byte address and a 16-bit byte length.
- Splits each descriptor into read requests that never cross a MAX_REQ_BYTES-aligned boundary, and therefore never cross a 4 KB boundary.
- Presents the requests to the TLP request builder over a valid/ready handshake.

Parameters:
- MAX_REQ_BYTES, 512: maximum request size in bytes; power of two, 128..4096.
- ADDR_W, 40: address width; descriptor bits [55:16].
- LEN_W, 16: length width; descriptor bits [15:0].

Ports:
- clockCore  input  1  core clock.
- resetCore  input  1  asynchronous, active-high reset.
- enable  input  1  permits new descriptor pops; an in-flight descriptor always completes.
- fifoEmpty  input  1  FIFO empty flag.
- fifoData  input  56  FIFO head entry, valid while fifoEmpty=0.
- fifoPop  output  1  pop strobe to FIFO; combinational, one cycle per descriptor.
- reqValid  output  1  request valid.
- reqReady  input  1  request accepted when reqValid&reqReady.
- reqAddr  output  40  request byte address.
- reqLenDw  output  11  request length in DWORDs, 1..MAX_REQ_BYTES/4.
- reqLast  output  1  final request of the current descriptor.
- busy  output  1  descriptor in flight (state != IDLE).
- errDesc  output  1  one-cycle pulse: descriptor dropped.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal address and remaining-length registers 0.
- Reset is asynchronous and active-high. Asserting it mid-descriptor abandons the descriptor without completing it; no further requests for it after release.
- States: IDLE, ISSUE.
- IDLE:
  - fifoPop = enable & ~fifoEmpty.
  - On pop, decode addr = fifoData[55:16] and len = fifoData[15:0].
  - If len==0, addr[1:0]!=0 or len[1:0]!=0: pulse errDesc next cycle, stay IDLE, emit no request.
  - Otherwise load curAddr=addr and remBytes=len, compute the first chunk, and move to ISSUE. reqValid rises the cycle after fifoPop.
- Chunk rule: chunk = min(remBytes, MAX_REQ_BYTES - (curAddr mod MAX_REQ_BYTES)).
  - reqLenDw = chunk>>2.
  - reqLast = (chunk == remBytes).
- ISSUE:
  - reqValid=1; reqAddr, reqLenDw and reqLast are registered and held stable until the handshake completes.
  - On reqValid&reqReady with reqLast=1: go to IDLE with reqValid=0 next cycle. This leaves a one-cycle bubble between descriptors.
  - On reqValid&reqReady with reqLast=0: curAddr += chunk (modulo 2^40), remBytes -= chunk, recompute chunk. The next request is presented the following cycle, so back-to-back acceptance is possible within a descriptor.
- Throughput: one request per cycle within a descriptor when reqReady is held high.
- Address wrap: addition is modulo 2^40 with no flag.
- fifoPop is never asserted in ISSUE, never when fifoEmpty=1, and never when enable=0.
- Deasserting enable during ISSUE has no effect until the return to IDLE.

Optional Feature:
- Macro: DMA_DESC_SPLITTER_STATS_EN.
- Defined: adds output ports statDescCnt[15:0] and statReqCnt[15:0].
  - statDescCnt increments on every accepted (non-error) descriptor pop.
  - statReqCnt increments on every request handshake.
  - Both wrap modulo 2^16 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dma_desc_pkg:
  - DESC_W=56, ADDR_W=40, LEN_W=16.
  - Field LSB/MSB constants (ADDR_LSB=16, LEN_LSB=0).
  - State encodings (IDLE=0, ISSUE=1).
- Sub-module dma_chunk_calc: purely combinational; inputs curAddr and remBytes, outputs chunkBytes and isLast. Reused by the write path.

Test Plan:
- MAX_REQ_BYTES=512, descriptor addr=0x00_0000_0100, len=0x0400, reqReady=1 → three requests:
  - 0x100/64 DW/last=0
  - 0x200/128 DW/last=0
  - 0x400/64 DW/last=1
  - One fifoPop total; reqValid first asserted the cycle after the pop.
- Descriptor len=0x0000 → errDesc pulses one cycle, no reqValid, FIFO advances. Repeat with addr=0x...102 and with len=0x0006: same result.
- Descriptor addr=0xFF_FFFF_FF00, len=0x0200 → 0xFF_FFFF_FF00/64 DW/last=0, then 0x00_0000_0000/64 DW/last=1.
- Hold reqReady=0 for 5 cycles during the second request → reqValid, reqAddr, reqLenDw and reqLast stable all 5 cycles; sequence resumes unchanged.
- Two descriptors queued, enable=0 → no fifoPop. Set enable=1, then drop it during the first descriptor → the first completes, the second is not popped until enable returns.
- Assert resetCore while mid-descriptor and reqValid=1 → outputs 0 immediately, busy=0. After release with an empty FIFO, no requests. With the macro defined, both stat counters read 0.
